stop_watch_time_counter: RTL and testbench

//  Stopwatch timekeeping datapath; consumes the run/stop and clear flags from the stopwatch button-control FSM.
//  - Divides clk down to a 1/100 s tick and counts centiseconds, seconds, minutes and hours while running.
//  - Holds the count while stopped.
//  - Zeroes the count on clear.
//  - Outputs feed the FND/display formatter.

---
 rtl/stop_watch_time_counter_pkg.sv | 30 +++
 rtl/stop_watch_time_counter_counter.sv | 30 +++
 rtl/stop_watch_time_counter_prescaler.sv | 33 +++
 rtl/stop_watch_time_counter.sv | 97 +++++++++
 tb/tb_stop_watch_time_counter.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/stop_watch_time_counter_pkg.sv
// Shared stopwatch constants: field limits, field widths and default clock rates.
// Also provides the time-of-day bundle that is handed to the display formatter.
package stop_watch_time_counter_pkg;

    localparam int MSEC_MAX = 99;
    localparam int SEC_MAX  = 59;
    localparam int MIN_MAX  = 59;
    localparam int HOUR_MAX = 23;

    localparam int MSEC_W = 7;
    localparam int SEC_W  = 6;
    localparam int MIN_W  = 6;
    localparam int HOUR_W = 5;

    localparam int DEFAULT_CLK_HZ  = 100_000_000;
    localparam int DEFAULT_TICK_HZ = 100;

    typedef struct packed {
        logic [HOUR_W-1:0] hour;
        logic [MIN_W-1:0]  min;
        logic [SEC_W-1:0]  sec;
        logic [MSEC_W-1:0] msec;
    } sw_time_t;

    // A divide-by-one prescaler still needs a one-bit register to stay legal.
    function automatic int prescWidth(input int div);
        return (div <= 1) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/stop_watch_time_counter_counter.sv
// Modulo-(MAX+1) counter stage of the time cascade.
// Carries out only when the incoming carry finds the stage at its maximum.
module mod_counter #(
    parameter int MAX = 99,
    parameter int W   = 7
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         carry_in,
    output logic [W-1:0] count,
    output logic         carry_out
);

    logic [W-1:0] r_count;

    assign carry_out = carry_in & (r_count == W'(MAX));
    assign count     = r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (carry_in) begin
            r_count <= carry_out ? '0 : r_count + 1'b1;
        end
    end

endmodule

// File: rtl/stop_watch_time_counter_prescaler.sv
// Divides the running clock down to the centisecond tick.
// A pause freezes the count so the fractional centisecond is kept.
module tick_prescaler
    import stop_watch_time_counter_pkg::*;
#(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int W = prescWidth(DIV);
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] r_count;

    // With DIV=1 LAST is zero, so every enabled cycle produces a tick.
    assign tick = en & ~clr & (r_count == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (en) begin
            r_count <= (r_count == LAST) ? '0 : r_count + 1'b1;
        end
    end

endmodule

// File: rtl/stop_watch_time_counter.sv
// Stopwatch timekeeping datapath: prescaler feeding a centisecond/second/minute/hour cascade.
// Clear overrides run; tick and rollover pulses are registered alongside the count.
module stop_watch_time_counter
    import stop_watch_time_counter_pkg::*;
#(
    parameter int CLK_HZ  = DEFAULT_CLK_HZ,
    parameter int TICK_HZ = DEFAULT_TICK_HZ
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run_stop_flag,
    input  logic              clear_flag,
    output logic [MSEC_W-1:0] o_msec,
    output logic [SEC_W-1:0]  o_sec,
    output logic [MIN_W-1:0]  o_min,
    output logic [HOUR_W-1:0] o_hour,
    output logic              o_tick,
    output logic              o_rollover
);

    localparam int DIV = CLK_HZ / TICK_HZ;

    logic     w_tick;
    logic     w_msec_carry;
    logic     w_sec_carry;
    logic     w_min_carry;
    logic     w_hour_carry;
    sw_time_t w_time;
    logic     r_tick;
    logic     r_rollover;

    tick_prescaler #(.DIV(DIV)) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .en    (run_stop_flag),
        .clr   (clear_flag),
        .tick  (w_tick)
    );

    mod_counter #(.MAX(MSEC_MAX), .W(MSEC_W)) u_msec_cnt (
        .clk       (clk),
        .reset     (reset),
        .clr       (clear_flag),
        .carry_in  (w_tick),
        .count     (w_time.msec),
        .carry_out (w_msec_carry)
    );

    mod_counter #(.MAX(SEC_MAX), .W(SEC_W)) u_sec_cnt (
        .clk       (clk),
        .reset     (reset),
        .clr       (clear_flag),
        .carry_in  (w_msec_carry),
        .count     (w_time.sec),
        .carry_out (w_sec_carry)
    );

    mod_counter #(.MAX(MIN_MAX), .W(MIN_W)) u_min_cnt (
        .clk       (clk),
        .reset     (reset),
        .clr       (clear_flag),
        .carry_in  (w_sec_carry),
        .count     (w_time.min),
        .carry_out (w_min_carry)
    );

    mod_counter #(.MAX(HOUR_MAX), .W(HOUR_W)) u_hour_cnt (
        .clk       (clk),
        .reset     (reset),
        .clr       (clear_flag),
        .carry_in  (w_min_carry),
        .count     (w_time.hour),
        .carry_out (w_hour_carry)
    );

    // The hour carry is the full-day wrap; both pulses land on the cycle after the counting edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tick     <= 1'b0;
            r_rollover <= 1'b0;
        end else if (clear_flag) begin
            r_tick     <= 1'b0;
            r_rollover <= 1'b0;
        end else begin
            r_tick     <= w_tick;
            r_rollover <= w_hour_carry;
        end
    end

    assign o_msec     = w_time.msec;
    assign o_sec      = w_time.sec;
    assign o_min      = w_time.min;
    assign o_hour     = w_time.hour;
    assign o_tick     = r_tick;
    assign o_rollover = r_rollover;

endmodule

// File: tb/tb_stop_watch_time_counter.sv
// Stopwatch datapath bench: a DIV=10 instance for the main scenarios and a DIV=1 instance for the day wrap.
// Expected values come from a centisecond-total model of elapsed running time.
module tb_stop_watch_time_counter;

    localparam int DAY = 24 * 60 * 60 * 100;

    logic       clk = 1'b0;
    logic       reset;
    logic       run;
    logic       clr;
    logic       run1;
    logic       clr1;
    logic [6:0] o_msec,  o1_msec;
    logic [5:0] o_sec,   o1_sec;
    logic [5:0] o_min,   o1_min;
    logic [4:0] o_hour,  o1_hour;
    logic       o_tick,  o1_tick;
    logic       o_rollover, o1_rollover;

    int testsRun    = 0;
    int testsFailed = 0;

    int mTotal = 0, mPresc = 0;
    bit mTick = 0, mRoll = 0;
    int nTotal = 0, nPresc = 0;
    bit nTick = 0, nRoll = 0;

    stop_watch_time_counter #(.CLK_HZ(1000), .TICK_HZ(100)) dut (
        .clk           (clk),
        .reset         (reset),
        .run_stop_flag (run),
        .clear_flag    (clr),
        .o_msec        (o_msec),
        .o_sec         (o_sec),
        .o_min         (o_min),
        .o_hour        (o_hour),
        .o_tick        (o_tick),
        .o_rollover    (o_rollover)
    );

    stop_watch_time_counter #(.CLK_HZ(100), .TICK_HZ(100)) dut1 (
        .clk           (clk),
        .reset         (reset),
        .run_stop_flag (run1),
        .clear_flag    (clr1),
        .o_msec        (o1_msec),
        .o_sec         (o1_sec),
        .o_min         (o1_min),
        .o_hour        (o1_hour),
        .o_tick        (o1_tick),
        .o_rollover    (o1_rollover)
    );

    always #5 clk = ~clk;

    function automatic logic [25:0] expVec(input int total, input bit t, input bit r);
        int hh, mm, ss, cs;
        hh = total / 360000;
        mm = (total / 6000) % 60;
        ss = (total / 100) % 60;
        cs = total % 100;
        return {5'(hh), 6'(mm), 6'(ss), 7'(cs), t, r};
    endfunction

    task automatic advanceModel(input int div, input logic r, input logic c,
                                inout int total, inout int presc,
                                output bit tick, output bit roll);
        tick = 0;
        roll = 0;
        if (c) begin
            total = 0;
            presc = 0;
        end else if (r) begin
            if (presc == div - 1) begin
                presc = 0;
                tick  = 1;
                total = (total + 1) % DAY;
                roll  = (total == 0);
            end else begin
                presc++;
            end
        end
    endtask

    task automatic zeroModels();
        mTotal = 0; mPresc = 0; mTick = 0; mRoll = 0;
        nTotal = 0; nPresc = 0; nTick = 0; nRoll = 0;
    endtask

    task automatic applyStimulus(input logic r, input logic c);
        run = r;
        clr = c;
    endtask

    task automatic stepEdge();
        @(posedge clk);
        advanceModel(10, run, clr, mTotal, mPresc, mTick, mRoll);
        advanceModel(1, run1, clr1, nTotal, nPresc, nTick, nRoll);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag);
        logic [25:0] got, want;
        got  = {o_hour, o_min, o_sec, o_msec, o_tick, o_rollover};
        want = expVec(mTotal, mTick, mRoll);
        testsRun++;
        assert (got === want) else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, got, want);
        end
    endtask

    task automatic checkOutput1(input string tag);
        logic [25:0] got, want;
        got  = {o1_hour, o1_min, o1_sec, o1_msec, o1_tick, o1_rollover};
        want = expVec(nTotal, nTick, nRoll);
        testsRun++;
        assert (got === want) else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, got, want);
        end
    endtask

    task automatic checkValue(input string tag, input int got, input int want);
        testsRun++;
        assert (got === want) else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, got, want);
        end
    endtask

    task automatic runSteps(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            stepEdge();
            checkOutput(tag);
        end
    endtask

    // Called just after a falling edge: reset pulses for 3 ns well clear of the next rising edge.
    task automatic resetPulse(input string tag);
        #1 reset = 1'b1;
        zeroModels();
        #1 checkOutput(tag);
        checkValue({tag, "_msec"}, int'(o_msec), 0);
        #2 reset = 1'b0;
    endtask

    int rollCount;

    initial begin
        reset = 1'b1;
        run   = 1'b0;
        clr   = 1'b0;
        run1  = 1'b0;
        clr1  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        checkOutput("reset_state");

        // Reset asserted asynchronously while counting, then idle with run low.
        applyStimulus(1'b1, 1'b0);
        runSteps(25, "pre_reset_run");
        checkValue("pre_reset_msec", int'(o_msec), 2);
        applyStimulus(1'b0, 1'b0);
        resetPulse("async_reset");
        runSteps(100, "idle_after_reset");

        // First tick latency and the second/minute carries.
        applyStimulus(1'b1, 1'b0);
        runSteps(9, "run_before_tick");
        checkValue("no_tick_before_div", int'(o_msec), 0);
        runSteps(1, "run_first_tick");
        checkValue("first_tick_msec", int'(o_msec), 1);
        checkValue("first_tick_pulse", int'(o_tick), 1);
        runSteps(1, "tick_drops");
        checkValue("tick_single_cycle", int'(o_tick), 0);
        runSteps(989, "run_to_second");
        checkValue("one_second_sec", int'(o_sec), 1);
        checkValue("one_second_msec", int'(o_msec), 0);
        runSteps(59000, "run_to_minute");
        checkValue("one_minute_min", int'(o_min), 1);
        checkValue("one_minute_sec", int'(o_sec), 0);

        // Pause keeps the fractional centisecond.
        applyStimulus(1'b0, 1'b1);
        runSteps(1, "clear_before_pause");
        applyStimulus(1'b1, 1'b0);
        runSteps(15, "pause_run");
        checkValue("pause_run_msec", int'(o_msec), 1);
        applyStimulus(1'b0, 1'b0);
        runSteps(50, "paused");
        checkValue("paused_msec", int'(o_msec), 1);
        applyStimulus(1'b1, 1'b0);
        runSteps(4, "resume");
        checkValue("resume_not_yet", int'(o_msec), 1);
        runSteps(1, "resume_tick");
        checkValue("resume_msec", int'(o_msec), 2);

        // Clear at 37 centiseconds, re-arm latency, clear coincident with a tick.
        applyStimulus(1'b0, 1'b1);
        runSteps(1, "clear_zero");
        applyStimulus(1'b1, 1'b0);
        runSteps(370, "run_to_37");
        checkValue("at_37", int'(o_msec), 37);
        applyStimulus(1'b1, 1'b1);
        runSteps(1, "clear_pulse");
        checkValue("cleared_msec", int'(o_msec), 0);
        applyStimulus(1'b1, 1'b0);
        runSteps(9, "after_clear");
        checkValue("after_clear_msec", int'(o_msec), 0);
        runSteps(1, "after_clear_tick");
        checkValue("after_clear_tick_msec", int'(o_msec), 1);
        runSteps(9, "approach_tick");
        applyStimulus(1'b1, 1'b1);
        runSteps(1, "clear_on_tick");
        checkValue("clear_on_tick_msec", int'(o_msec), 0);
        checkValue("clear_on_tick_pulse", int'(o_tick), 0);

        // Run dropping on the tick edge leaves the prescaler parked at its last count.
        applyStimulus(1'b1, 1'b0);
        runSteps(9, "approach_stop");
        applyStimulus(1'b0, 1'b0);
        runSteps(4, "stop_on_tick");
        checkValue("stop_on_tick_msec", int'(o_msec), 0);
        applyStimulus(1'b1, 1'b0);
        runSteps(1, "restart_ticks_now");
        checkValue("restart_msec", int'(o_msec), 1);
        checkValue("restart_pulse", int'(o_tick), 1);

        // Random run/clear traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(($urandom_range(0, 9) < 8), ($urandom_range(0, 49) == 0));
            stepEdge();
            checkOutput("random");
        end

        // Reset in the middle of 00:00:01.50 and restart.
        applyStimulus(1'b0, 1'b1);
        runSteps(1, "clear_before_mid");
        applyStimulus(1'b1, 1'b0);
        runSteps(1500, "run_to_1s50");
        checkValue("mid_sec", int'(o_sec), 1);
        checkValue("mid_msec", int'(o_msec), 50);
        resetPulse("mid_run_reset");
        runSteps(9, "after_mid_reset");
        runSteps(1, "after_mid_reset_tick");
        checkValue("after_mid_reset_msec", int'(o_msec), 1);

        // Day wrap on the divide-by-one instance, preloaded to 23:59:59.98 while stopped.
        applyStimulus(1'b0, 1'b0);
        force dut1.u_hour_cnt.r_count = 5'd23;
        force dut1.u_min_cnt.r_count  = 6'd59;
        force dut1.u_sec_cnt.r_count  = 6'd59;
        force dut1.u_msec_cnt.r_count = 7'd98;
        #1;
        release dut1.u_hour_cnt.r_count;
        release dut1.u_min_cnt.r_count;
        release dut1.u_sec_cnt.r_count;
        release dut1.u_msec_cnt.r_count;
        nTotal = DAY - 2;
        nPresc = 0;
        #1 checkOutput1("preload");
        run1 = 1'b1;
        stepEdge();
        checkOutput1("at_23_59_59_99");
        checkValue("last_hour", int'(o1_hour), 23);
        checkValue("last_msec", int'(o1_msec), 99);
        rollCount = 0;
        for (int i = 0; i < 200; i++) begin
            stepEdge();
            checkOutput1("wrap_run");
            if (o1_rollover) rollCount++;
            if (i == 0) begin
                checkValue("wrap_zero", int'({o1_hour, o1_min, o1_sec, o1_msec}), 0);
                checkValue("wrap_pulse", int'(o1_rollover), 1);
            end
        end
        checkValue("rollover_count", rollCount, 1);
        run1 = 1'b0;

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
